// File: rtl/cci_mpf_shim_vtp_miss_queue_pkg.sv
// Shared VTP constants and page-match helpers for the TLB miss queue.
package cci_mpf_shim_vtp_miss_queue_pkg;

    localparam int VTP_VA_PAGE_BITS   = 36;
    localparam int VTP_2MB_PAGE_SHIFT = 9;

    // Channel identifiers; also the type of the round-robin priority pointer.
    typedef enum logic { CH_C0 = 1'b0, CH_C1 = 1'b1 } t_chan;

    // Callers zero-extend page indices to 64 bits so one helper serves any VA width.
    function automatic logic [63:0] vtp4kbTo2mbVA(input logic [63:0] va);
        return va >> VTP_2MB_PAGE_SHIFT;
    endfunction

    function automatic logic vtp_page_match(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic        big);
        return big ? (vtp4kbTo2mbVA(a) == vtp4kbTo2mbVA(b)) : (a == b);
    endfunction

endpackage

// File: rtl/cci_mpf_shim_vtp_miss_queue_filter.sv
// Duplicate filter for one miss channel: hits on queued, active, issuing or filling pages.
module cci_mpf_shim_vtp_miss_queue_filter
    import cci_mpf_shim_vtp_miss_queue_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int VA_PAGE_BITS = VTP_VA_PAGE_BITS
)(
    input  logic [VA_PAGE_BITS-1:0]            i_miss_va,
    input  logic [DEPTH-1:0][VA_PAGE_BITS-1:0] i_slot_va,
    input  logic [DEPTH-1:0]                   i_slot_live,
    input  logic                               i_active_valid,
    input  logic [VA_PAGE_BITS-1:0]            i_active_va,
    input  logic                               i_issue_en,
    input  logic [VA_PAGE_BITS-1:0]            i_issue_va,
    input  logic                               i_fill_en,
    input  logic                               i_fill_big,
    input  logic [VA_PAGE_BITS-1:0]            i_fill_va,
    output logic                               o_dup
);

    logic [DEPTH-1:0] w_slot_hit;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_hit[i] = i_slot_live[i] && (i_slot_va[i] == i_miss_va);
        end
    end

    assign o_dup = (|w_slot_hit)
                || (i_active_valid && (i_active_va == i_miss_va))
                || (i_issue_en && (i_issue_va == i_miss_va))
                || (i_fill_en && vtp_page_match(64'(i_fill_va), 64'(i_miss_va), i_fill_big));

endmodule

// File: rtl/cci_mpf_shim_vtp_miss_queue.sv
// Deduplicating, ordered TLB miss queue between the dual-channel VTP lookup and the page walker.
module cci_mpf_shim_vtp_miss_queue
    import cci_mpf_shim_vtp_miss_queue_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int VA_PAGE_BITS   = VTP_VA_PAGE_BITS,
    parameter int DEBUG_MESSAGES = 0
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              missEn,
    input  logic [VA_PAGE_BITS-1:0] missVA [0:1],
    output logic                    walkReqEn,
    output logic [VA_PAGE_BITS-1:0] walkReqVA,
    input  logic                    walkReqRdy,
    input  logic                    walkDone,
    input  logic                    fillEn,
    input  logic                    fillBigPage,
    input  logic [VA_PAGE_BITS-1:0] fillVA,
    output logic [1:0]              statDup,
    output logic [1:0]              statDrop
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic                    live;
        logic [VA_PAGE_BITS-1:0] va;
    } t_slot;

    t_slot                   r_slot [DEPTH];
    logic [PTR_W-1:0]        r_head, r_tail;
    logic                    r_active_valid;
    logic [VA_PAGE_BITS-1:0] r_active_va;
    t_chan                   r_rr;
    logic [1:0]              r_stat_dup, r_stat_drop;

    logic [PTR_W-1:0]                   w_count, w_free;
    logic [IDX_W-1:0]                   w_head_idx, w_tail_idx, w_tail_idx_nx;
    logic                               w_empty, w_head_live, w_xfer, w_pop;
    logic [DEPTH-1:0][VA_PAGE_BITS-1:0] w_slot_va;
    logic [DEPTH-1:0]                   w_slot_live;
    logic [1:0]                         w_dup, w_want, w_stat_dup, w_stat_drop, w_enq_cnt;
    logic [VA_PAGE_BITS-1:0]            w_enq_va [0:1];
    logic                               w_rr_flip;
    t_chan                              w_first, w_second;

    assign w_count       = r_tail - r_head;
    assign w_empty       = (w_count == '0);
    assign w_head_idx    = r_head[IDX_W-1:0];
    assign w_tail_idx    = r_tail[IDX_W-1:0];
    assign w_tail_idx_nx = w_tail_idx + IDX_W'(1);
    assign w_head_live   = !w_empty && r_slot[w_head_idx].live;

    // Killed heads drain one per cycle even while a walk is active.
    assign walkReqEn = w_head_live && !r_active_valid;
    assign walkReqVA = walkReqEn ? r_slot[w_head_idx].va : '0;
    assign w_xfer    = walkReqEn && walkReqRdy;
    assign w_pop     = w_xfer || (!w_empty && !w_head_live);
    assign w_free    = PTR_W'(DEPTH) - w_count + PTR_W'(w_pop);

    assign w_first  = r_rr;
    assign w_second = t_chan'(~r_rr);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_va[i]   = r_slot[i].va;
            w_slot_live[i] = r_slot[i].live;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_filter
        cci_mpf_shim_vtp_miss_queue_filter #(
            .DEPTH        (DEPTH),
            .VA_PAGE_BITS (VA_PAGE_BITS)
        ) u_filter (
            .i_miss_va      (missVA[c]),
            .i_slot_va      (w_slot_va),
            .i_slot_live    (w_slot_live),
            .i_active_valid (r_active_valid),
            .i_active_va    (r_active_va),
            .i_issue_en     (w_xfer),
            .i_issue_va     (walkReqVA),
            .i_fill_en      (fillEn),
            .i_fill_big     (fillBigPage),
            .i_fill_va      (fillVA),
            .o_dup          (w_dup[c])
        );
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        w_want      = missEn & ~w_dup;
        w_stat_dup  = missEn & w_dup;
        w_stat_drop = '0;
        w_enq_cnt   = '0;
        w_enq_va[0] = missVA[w_first];
        w_enq_va[1] = missVA[w_second];
        w_rr_flip   = 1'b0;
        if (w_want[w_first] && w_want[w_second]) begin
            if (missVA[0] == missVA[1]) begin
                w_stat_dup[w_second] = 1'b1;
                w_rr_flip            = 1'b1;
                if (w_free != '0) w_enq_cnt = 2'd1;
                else              w_stat_drop[w_first] = 1'b1;
            end else if (w_free >= PTR_W'(2)) begin
                w_enq_cnt = 2'd2;
            end else if (w_free == PTR_W'(1)) begin
                w_enq_cnt             = 2'd1;
                w_stat_drop[w_second] = 1'b1;
                w_rr_flip             = 1'b1;
            end else begin
                w_stat_drop = 2'b11;
            end
        end else if (|w_want) begin
            w_enq_va[0] = w_want[CH_C1] ? missVA[1] : missVA[0];
            if (w_free != '0) w_enq_cnt = 2'd1;
            else              w_stat_drop = w_want;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the slot array is reset as well; its live bits feed the duplicate filter.
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_active_valid <= 1'b0;
            r_active_va    <= '0;
            r_rr           <= CH_C0;
            r_stat_dup     <= '0;
            r_stat_drop    <= '0;
        end else begin
            // NOTE: the last non-blocking write to a slot wins, so pop, kill, enqueue run oldest first.
            if (w_pop) r_slot[w_head_idx].live <= 1'b0;
            if (fillEn) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (vtp_page_match(64'(r_slot[i].va), 64'(fillVA), fillBigPage))
                        r_slot[i].live <= 1'b0;
                end
            end
            if (w_enq_cnt != 2'd0) r_slot[w_tail_idx]    <= t_slot'{live: 1'b1, va: w_enq_va[0]};
            if (w_enq_cnt == 2'd2) r_slot[w_tail_idx_nx] <= t_slot'{live: 1'b1, va: w_enq_va[1]};
            r_head <= r_head + PTR_W'(w_pop);
            r_tail <= r_tail + PTR_W'(w_enq_cnt);
            if (w_xfer) begin
                r_active_valid <= 1'b1;
                r_active_va    <= r_slot[w_head_idx].va;
            end else if (walkDone) begin
                r_active_valid <= 1'b0;
            end
            if (w_rr_flip) r_rr <= t_chan'(~r_rr);
            r_stat_dup  <= w_stat_dup;
            r_stat_drop <= w_stat_drop;
        end
    end

    assign statDup  = r_stat_dup;
    assign statDrop = r_stat_drop;

    always @(posedge clk) begin
        if (reset) begin
            assert (!(walkDone && !r_active_valid))
                else $warning("miss_queue: walkDone with no active walk, ignored");
        end
    end

    if (DEBUG_MESSAGES != 0) begin : g_debug
        always @(posedge clk) begin
            if (reset) begin
                if (w_enq_cnt != 2'd0) $info("miss_queue: enqueue %h (count %0d)", w_enq_va[0], w_enq_cnt);
                if (w_xfer) $info("miss_queue: issue %h", walkReqVA);
                if (walkDone && r_active_valid) $info("miss_queue: retire %h", r_active_va);
            end
        end
    end

endmodule
